// File: rtl/io_event_fifo.sv
// io_event_fifo: memory-mapped input-event responder.
// Synchronises two 4-bit switch ports and timestamps every change of their
// combined value. Each change is queued in a small FIFO that the CPU drains
// with loads from DATA. CTRL stores enable capture, flush the queue and
// clear the timestamp. Register map (addr[7]=1): 0x80 STATUS, 0x84 DATA,
// 0x88 CTRL, 0x8C TIME.
module io_event_fifo #(
  parameter int DEPTH = 8,   // power of two, 2..16
  parameter int TS_W  = 16   // <= 16
) (
  input  logic        clock,
  input  logic        clr,
  input  logic [7:0]  addr,
  input  logic        rd,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [3:0]  in_port0,
  input  logic [3:0]  in_port1,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // Synchroniser stages and change-detect history
  logic [3:0]      r_meta0, r_meta1, r_sync0, r_sync1;
  logic [7:0]      r_prev;
  // Control / FIFO state
  logic            r_en, r_ovf;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [TS_W-1:0] r_ts;
  // Entry storage: {timestamp zero-extended to 16 bits, sample}
  logic [23:0]     r_mem [DEPTH];

  logic [7:0]  w_s;
  logic        w_sel_status, w_sel_data, w_sel_ctrl, w_sel_time;
  logic        w_empty, w_full, w_chg, w_pop, w_push, w_drop;
  logic        w_ctrl_wr, w_flush, w_tsclr;
  logic [4:0]  w_cnt_ext;
  logic [23:0] w_head;
  logic        w_unused;

  assign w_s = {r_sync1, r_sync0};

  // Word decode on addr[7:2]; the byte offset is irrelevant
  assign w_sel_status = (addr[7:2] == 6'h20);
  assign w_sel_data   = (addr[7:2] == 6'h21);
  assign w_sel_ctrl   = (addr[7:2] == 6'h22);
  assign w_sel_time   = (addr[7:2] == 6'h23);

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_chg   = r_en & (w_s != r_prev);

  // A pop only happens on a non-empty FIFO, so a pop+push on an empty FIFO
  // degenerates to a plain push. A full FIFO accepts a push when a pop
  // frees the head in the same cycle.
  assign w_pop  = rd & w_sel_data & ~w_empty;
  assign w_push = w_chg & (~w_full | w_pop);
  assign w_drop = w_chg & w_full & ~w_pop;

  assign w_ctrl_wr = we & w_sel_ctrl;
  assign w_flush   = w_ctrl_wr & wdata[1];
  assign w_tsclr   = w_ctrl_wr & wdata[2];

  // STATUS count field is 4 bits; with DEPTH=16 a full FIFO shows count 0
  // and relies on the full flag.
  assign w_cnt_ext = 5'(r_cnt);
  assign w_head    = r_mem[r_rptr];
  assign irq       = ~w_empty;

  assign w_unused = ^{addr[1:0], wdata[31:3], w_cnt_ext[4]};

  // Synchroniser, timestamp, control register and FIFO bookkeeping
  always_ff @(posedge clock) begin
    if (clr) begin
      r_meta0 <= '0;
      r_meta1 <= '0;
      r_sync0 <= '0;
      r_sync1 <= '0;
      r_prev  <= '0;
      r_en    <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ts    <= '0;
    end else begin
      r_meta0 <= in_port0;
      r_meta1 <= in_port1;
      r_sync0 <= r_meta0;
      r_sync1 <= r_meta1;
      r_prev  <= w_s;
      r_ts    <= w_tsclr ? '0 : r_ts + 1'b1;
      if (w_ctrl_wr) r_en <= wdata[0];
      // Flush overrides any push or pop in the same cycle
      if (w_flush) begin
        r_cnt  <= '0;
        r_wptr <= '0;
        r_rptr <= '0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        if (w_drop) r_ovf <= 1'b1;
      end
    end
  end

  // Entry storage; contents are only visible while count > 0, so no reset
  always_ff @(posedge clock) begin
    if (!clr && w_push && !w_flush)
      r_mem[r_wptr] <= {16'(r_ts), w_s};
  end

  // Combinational read mux
  always_comb begin
    rdata = '0;
    if (addr[7]) begin
      if (w_sel_status)
        rdata = {16'b0, w_s, r_en, r_ovf, w_full, w_empty, w_cnt_ext[3:0]};
      else if (w_sel_data)
        rdata = w_empty ? 32'b0 : {w_head[23:8], 8'b0, w_head[7:0]};
      else if (w_sel_ctrl)
        rdata = {31'b0, r_en};
      else if (w_sel_time)
        rdata = 32'(r_ts);
    end
  end

endmodule

// File: doc/io_event_fifo.md
# io_event_fifo

Memory-mapped input-event responder on the pipelined CPU's data-memory/I/O bus, at I/O address space `addr[7]=1` alongside the input and output port registers. It synchronises the two 4-bit input ports and timestamps every change of their combined value. Each change is pushed into a small FIFO that the CPU drains with ordinary loads. Stores to a control register enable capture, flush the FIFO and clear the timestamp.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, 2..16.
- `TS_W`, 16: timestamp counter width; must be ≤ 16.
- `clock`  in  1: single clock, rising edge.
- `clr`  in  1: synchronous, active-high reset.
- `addr`  in  8: byte address (ALU result bits [7:0]); decoded on `addr[7:2]`; `addr[1:0]` ignored.
- `rd`  in  1: load strobe, high for one cycle per load.
- `we`  in  1: store strobe.
- `wdata`  in  32: store data.
- `in_port0`  in  4: asynchronous switch input.
- `in_port1`  in  4: asynchronous switch input.
- `rdata`  out  32: combinational read data for `addr`.
- `irq`  out  1: high whenever the FIFO is non-empty.

## Operation
- **Address map**, active only when `addr[7]=1`; other addresses return 0 and ignore writes.
  - 0x80 STATUS (read only): `[3:0]`=count, `[4]`=empty, `[5]`=full, `[6]`=overflow (sticky), `[7]`=enable, `[15:8]`={sync1,sync0}, rest 0.
  - 0x84 DATA: returns the head entry.
    - Load (`rd`) pops the entry when not empty.
    - Load when empty returns 0; no state change.
  - 0x88 CTRL (write): `bit0`=enable (stored), `bit1`=flush (one-shot), `bit2`=clear timestamp (one-shot). Read returns {31'b0, enable}.
  - 0x8C TIME: reads the current timestamp, zero-extended. Writes are ignored.
- **Synchroniser:** two flops per port; sample `s={sync1,sync0}`, 8 bits. `prev` is loaded with `s` every cycle.
- **Change:** `chg = enable & (s != prev)`.
- **Entry format:** {ts[TS_W-1:0] zero-extended to 16 bits, 8'b0, s}.
- **Timestamp:** free-running, increments every cycle, wraps to 0. The CTRL bit2 write loads 0.
- **Push on `chg`:**
  - If not full, write the entry at wptr, wptr+1 mod DEPTH, count+1.
  - If full, drop the entry and set overflow.
- **Simultaneous events:**
  - Push and pop with count=full: both happen, count unchanged, no overflow.
  - Push and pop with count=0: pop ignored, push happens.
  - Flush the same cycle as push or pop: flush wins. Result is count=0, pointers 0, overflow=0, event lost.
  - Store and load in the same cycle: both are honoured.
- **Reset (`clr`):** all state is cleared.
  - Sync flops and `prev` = 0.
  - enable=0, count=0, pointers 0, overflow=0, timestamp=0.
  - `irq`=0. `rdata` reflects the reset state (STATUS reads 0x10).

## Timing
- **Input to entry:** an input change settled before edge k is captured in sync1 at k, in sync2 at k+1, and pushed at edge k+2. The stored timestamp is the counter value in the cycle before edge k+2. From edge k+2, count and `irq` reflect the entry.
- **Input glitch:** a change lasting one cycle produces two entries (change and restore) if it is sampled.
- **Load:** `rdata` is combinational in the cycle `rd` is high; the pop takes effect at that cycle's edge.
- **Store:** takes effect at the edge; enable=1 first allows pushes for the change detected in the following cycle.
- **Throughput:** one push and one pop per cycle maximum.

## Test plan
- **Reset:** assert `clr` for 2 cycles while inputs=0xF/0x3.
  - STATUS=0x10, `irq`=0, TIME=0.
  - Cycle 3 after release: STATUS[15:8]=0x3F, no entry (enable=0).
- **Single event:** write CTRL=0x5, then set in_port0 0→0x5.
  - Exactly one entry 3 edges later, `irq`=1.
  - DATA read gives low byte 0x05 with the expected timestamp; the next STATUS is empty.
- **Overflow:** enable, generate 9 changes with no reads.
  - STATUS count=8, full=1, overflow=1.
  - 8 reads return entries in order; the 9th read returns 0.
- **Full + simultaneous push/pop:** with 8 entries, a read at the same edge as a new change.
  - Count stays 8, overflow stays 0.
  - The new entry becomes the last entry.
- **Flush priority:** a CTRL=0x3 write at the same edge as a change.
  - Count=0, overflow=0, enable remains 1.
  - The next change is captured normally.
- **Wrap and clear:** with TS_W=4, run ≥20 cycles.
  - TIME wraps 0xF→0.
  - CTRL bit2 write gives TIME=0 the next cycle.
  - Pointer wrap is checked by 12 push/pop pairs, with data preserved.
